// File: rtl/dmem_io_scan_pkg.sv
// dmem_io_scan_pkg
// Shared constants and helpers for the data-memory / IO-scan block:
//   - IO register offsets within the 8-byte IO window
//   - active-low 7-segment encodings (bit0 = segment a)
//   - clog2 helper for sizing counters and address fields
package dmem_io_scan_pkg;

    localparam logic [2:0] IO_SWITCHES = 3'd0;
    localparam logic [2:0] IO_DISPDATA = 3'd2;
    localparam logic [2:0] IO_BLANK    = 3'd4;
    localparam logic [2:0] IO_STATUS   = 3'd6;

    // Common-anode encodings, {g,f,e,d,c,b,a}, 0 = segment lit
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Number of bits needed to hold values 0..value-1
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dmem_io_scan_hex7seg.sv
// hex7seg
// Combinational hex nibble to active-low 7-segment decode.
// Ports:
//   hex - 4-bit value to display
//   seg - segments a..g (bit0 = a), active-low
module hex7seg
    import dmem_io_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/dmem_io_scan.sv
// dmem_io_scan
// Word-addressed data RAM plus a small memory-mapped IO window holding
// debounced switches, a multiplexed hex display and a change flag.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   addr          - byte address (bit 0 ignored)
//   wdata, wr_en  - write data / strobe, committed on the rising edge
//   rd_en, rdata  - combinational read; rdata is 0 when rd_en is low
//   sw            - raw asynchronous switch levels
//   seg, an       - registered active-low segments and digit enables
module dmem_io_scan
    import dmem_io_scan_pkg::*;
#(
    parameter int          DEPTH        = 128,
    parameter int          NUM_SW       = 4,
    parameter int          NUM_DIGITS   = 4,
    parameter int          DEBOUNCE_CYC = 16,
    parameter int          SCAN_CYC     = 1024,
    parameter logic [15:0] IO_BASE      = 16'hFFF0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [15:0]           addr,
    input  logic [15:0]           wdata,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [15:0]           rdata,
    input  logic [NUM_SW-1:0]     sw,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int AW  = clog2(DEPTH);
    localparam int CW  = clog2(DEBOUNCE_CYC);
    localparam int SCW = clog2(SCAN_CYC);
    localparam int IW  = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
    localparam int DW  = 4 * NUM_DIGITS;

    logic [15:0]           mem [DEPTH];
    logic [15:0]           word_addr;
    logic                  ram_sel;
    logic                  io_sel;
    logic [2:0]            io_off;
    logic                  io_wr;
    logic                  status_rd;

    logic [DW-1:0]         dispdata;
    logic [NUM_DIGITS-1:0] blank;
    logic                  changed;

    logic [NUM_SW-1:0]     sync1;
    logic [NUM_SW-1:0]     sync2;
    logic [NUM_SW-1:0]     deb;
    logic [NUM_SW-1:0]     deb_next;
    logic [CW-1:0]         cnt      [NUM_SW];
    logic [CW-1:0]         cnt_next [NUM_SW];

    logic [SCW-1:0]        scan;
    logic [IW-1:0]         idx;
    logic [3:0]            nibble;
    logic [6:0]            dec_seg;

    // Masking bit 0 keeps every address bit referenced while ignoring it
    assign word_addr = addr & 16'hFFFE;
    assign ram_sel   = word_addr[15:1] < 15'(DEPTH);
    // IO_BASE is assumed 8-byte aligned, so the window is a prefix match
    assign io_sel    = !ram_sel && (word_addr[15:3] == IO_BASE[15:3]);
    assign io_off    = word_addr[2:0];
    assign io_wr     = wr_en && io_sel;
    assign status_rd = rd_en && io_sel && (io_off == IO_STATUS);

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            if (ram_sel) begin
                rdata = mem[word_addr[AW:1]];
            end else if (io_sel) begin
                case (io_off)
                    IO_SWITCHES: rdata = 16'(deb);
                    IO_DISPDATA: rdata = 16'(dispdata);
                    IO_BLANK:    rdata = 16'(blank);
                    IO_STATUS:   rdata = {15'b0, changed};
                    default:     rdata = '0;
                endcase
            end
        end
    end

    // RAM has no reset so it maps onto distributed memory
    always_ff @(posedge clock) begin
        if (wr_en && ram_sel && !reset) begin
            mem[word_addr[AW:1]] <= wdata;
        end
    end

    // Counter advances only while the synchronized level disagrees with the
    // accepted level; the DEBOUNCE_CYC-th disagreeing cycle accepts it.
    always_comb begin
        deb_next = deb;
        for (int unsigned i = 0; i < NUM_SW; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != deb[i]) begin
                if (cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
                    deb_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    assign nibble = 4'(dispdata >> {idx, 2'b00});

    hex7seg u_hex7seg (
        .hex (nibble),
        .seg (dec_seg)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            dispdata <= '0;
            blank    <= '0;
            changed  <= 1'b0;
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            for (int unsigned i = 0; i < NUM_SW; i++) begin
                cnt[i] <= '0;
            end
            scan     <= '0;
            idx      <= '0;
            an       <= ~NUM_DIGITS'(1);
            seg      <= SEG_0;
        end else begin
            if (io_wr && (io_off == IO_DISPDATA)) begin
                dispdata <= wdata[DW-1:0];
            end
            if (io_wr && (io_off == IO_BLANK)) begin
                blank <= wdata[NUM_DIGITS-1:0];
            end

            sync1 <= sw;
            sync2 <= sync1;
            deb   <= deb_next;
            cnt   <= cnt_next;

            // A flip on the same edge as a STATUS read keeps the flag set
            if (deb_next != deb) begin
                changed <= 1'b1;
            end else if (status_rd) begin
                changed <= 1'b0;
            end

            if (scan == SCW'(SCAN_CYC - 1)) begin
                scan <= '0;
                idx  <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                scan <= scan + 1'b1;
            end

            // Both outputs come from the same idx, so they change together
            an  <= ~(NUM_DIGITS'(1) << idx);
            seg <= blank[idx] ? SEG_BLANK : dec_seg;
        end
    end

endmodule

// File: tb/tb_dmem_io_scan.sv
// tb_dmem_io_scan
// Directed bench for dmem_io_scan with DEBOUNCE_CYC=4, SCAN_CYC=4.
// Inputs change on the falling edge; outputs are sampled before the next
// rising edge.
module tb_dmem_io_scan;

    localparam logic [15:0] A_SW    = 16'hFFF0;
    localparam logic [15:0] A_DISP  = 16'hFFF2;
    localparam logic [15:0] A_BLANK = 16'hFFF4;
    localparam logic [15:0] A_STAT  = 16'hFFF6;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] rdata;
    logic [3:0]  sw;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    dmem_io_scan #(
        .DEPTH        (128),
        .NUM_SW       (4),
        .NUM_DIGITS   (4),
        .DEBOUNCE_CYC (4),
        .SCAN_CYC     (4),
        .IO_BASE      (16'hFFF0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .rdata (rdata),
        .sw    (sw),
        .seg   (seg),
        .an    (an)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Combinational read without letting rd_en span a clock edge
    task automatic peek(input logic [15:0] a, output logic [15:0] v);
        addr  = a;
        rd_en = 1'b1;
        #1 v  = rdata;
        rd_en = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] v;
        @(negedge clock);
        peek(a, v);
        check(tag, v, exp);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clock);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        rd_en = 1'b0;
        @(posedge clock);
        #1 wr_en = 1'b0;
    endtask

    // Read STATUS across a rising edge so the flag clear takes effect
    task automatic status_read_edge();
        @(negedge clock);
        addr  = A_STAT;
        rd_en = 1'b1;
        @(posedge clock);
        #1 rd_en = 1'b0;
    endtask

    task automatic scan_run(input int n, input logic [3:0] bl);
        logic [3:0] prev;
        logic [6:0] e;
        int         run;
        bit         first_run;
        prev = 4'hF;
        run = 0;
        first_run = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            case (an)
                4'b1110: e = bl[0] ? 7'b1111111 : 7'b1111001;
                4'b1101: e = bl[1] ? 7'b1111111 : 7'b0001110;
                4'b1011: e = bl[2] ? 7'b1111111 : 7'b1000000;
                4'b0111: e = bl[3] ? 7'b1111111 : 7'b0000000;
                default: begin
                    e = 7'b1111111;
                    check("an_onehot", {12'b0, an}, 16'h000E);
                end
            endcase
            check("seg", {9'b0, seg}, {9'b0, e});
            if (i == 0) begin
                prev = an;
                run = 1;
            end else if (an == prev) begin
                run++;
            end else begin
                check("an_order", {12'b0, an}, {12'b0, prev[2:0], prev[3]});
                if (!first_run) check("scan_len", 16'(run), 16'd4);
                first_run = 1'b0;
                prev = an;
                run = 1;
            end
        end
    endtask

    initial begin
        logic [15:0] v;
        reset = 1'b1;
        addr  = '0;
        wdata = '0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        sw    = '0;

        repeat (2) @(negedge clock);
        check("rst_an", {12'b0, an}, 16'h000E);
        check("rst_seg", {9'b0, seg}, 16'h0040);
        reset = 1'b0;

        // RAM write/read and read-during-write
        wr(16'h0010, 16'hBEEF);
        rdchk("ram_rd", 16'h0010, 16'hBEEF);
        @(negedge clock);
        addr  = 16'h0010;
        wdata = 16'h1234;
        wr_en = 1'b1;
        rd_en = 1'b1;
        #1 check("ram_rdw_old", rdata, 16'hBEEF);
        @(posedge clock);
        #1 wr_en = 1'b0;
        check("ram_rdw_new", rdata, 16'h1234);
        rd_en = 1'b0;
        #1 check("rd_idle", rdata, 16'h0000);
        rdchk("ram_odd_addr", 16'h0011, 16'h1234);

        // Unmapped and read-only writes
        wr(16'h8000, 16'h5555);
        rdchk("unmapped", 16'h8000, 16'h0000);
        wr(A_SW, 16'hFFFF);
        rdchk("sw_ro", A_SW, 16'h0000);

        // Debounce: a one-cycle glitch is rejected
        @(negedge clock);
        sw = 4'b0001;
        @(negedge clock);
        sw = 4'b0000;
        repeat (8) @(negedge clock);
        rdchk("glitch_sw", A_SW, 16'h0000);
        rdchk("glitch_stat", A_STAT, 16'h0000);

        // Debounce: a held level is accepted and flags CHANGED
        @(negedge clock);
        sw = 4'b0001;
        repeat (10) @(negedge clock);
        rdchk("held_sw", A_SW, 16'h0001);
        rdchk("held_stat", A_STAT, 16'h0001);
        status_read_edge();
        rdchk("stat_clr", A_STAT, 16'h0000);

        // Display scan
        wr(A_DISP, 16'h80F1);
        wr(A_BLANK, 16'h0000);
        rdchk("disp_rd", A_DISP, 16'h80F1);
        repeat (2) @(negedge clock);
        scan_run(20, 4'b0000);

        // Blanking of digit 2
        wr(A_BLANK, 16'h0004);
        rdchk("blank_rd", A_BLANK, 16'h0004);
        repeat (2) @(negedge clock);
        scan_run(20, 4'b0100);

        // Reset mid-debounce discards the partial count
        wr(16'h0010, 16'hBEEF);
        @(negedge clock);
        sw = 4'b0011;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        peek(A_SW, v);
        check("rst_deb_early", v, 16'h0000);
        @(negedge clock);
        peek(A_SW, v);
        check("rst_deb_full", v, 16'h0003);
        rdchk("rst_disp", A_DISP, 16'h0000);
        rdchk("rst_blank", A_BLANK, 16'h0000);
        rdchk("rst_ram_keep", 16'h0010, 16'hBEEF);

        // CHANGED set/clear collision
        status_read_edge();
        rdchk("stat_clr2", A_STAT, 16'h0000);
        @(negedge clock);
        sw = 4'b0000;
        repeat (5) @(negedge clock);
        addr  = A_STAT;
        rd_en = 1'b1;
        @(posedge clock);
        #1 rd_en = 1'b0;
        @(negedge clock);
        peek(A_STAT, v);
        check("collide_stat", v, 16'h0001);
        peek(A_SW, v);
        check("collide_sw", v, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
